// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle unsigned multiply/divide sequencer owning the HI/LO register pair.
// Shift-add multiply and restoring divide, one bit per cycle over SIZE cycles.
module hilo_muldiv_unit #(
    parameter int SIZE     = 32,
    parameter int CMD_SIZE = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [CMD_SIZE-1:0] cmd,
    input  logic [SIZE-1:0]     operand_a,
    input  logic [SIZE-1:0]     operand_b,
    output logic                busy,
    output logic                done,
    output logic                div_by_zero,
    output logic [SIZE-1:0]     hi,
    output logic [SIZE-1:0]     lo
);

    localparam int CNT_W = $clog2(SIZE) + 1;

    localparam logic [CMD_SIZE-1:0] CMD_MULT = CMD_SIZE'(0);
    localparam logic [CMD_SIZE-1:0] CMD_DIV  = CMD_SIZE'(1);
    localparam logic [CMD_SIZE-1:0] CMD_MTHI = CMD_SIZE'(2);
    localparam logic [CMD_SIZE-1:0] CMD_MTLO = CMD_SIZE'(3);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } state_t;

    state_t state, state_next;

    logic [CNT_W-1:0]  count;
    logic              last_step;
    logic              dbz_flag;

    logic [2*SIZE-1:0] mcand;
    logic [2*SIZE-1:0] acc;
    logic [2*SIZE-1:0] acc_step;
    logic [SIZE-1:0]   mplier;

    logic [SIZE-1:0]   divisor;
    logic [SIZE-1:0]   quot;
    logic [SIZE-1:0]   rem;
    logic [SIZE:0]     rem_shift;
    logic [SIZE:0]     rem_diff;
    logic [SIZE-1:0]   rem_step;
    logic [SIZE-1:0]   quot_step;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, status outputs and the single-step arithmetic for both engines.
    always_comb begin
        state_next  = state;
        busy        = (state != IDLE);
        done        = (state == DONE);
        div_by_zero = (state == DONE) && dbz_flag;
        last_step   = (count == CNT_W'(SIZE - 1));

        acc_step  = acc + (mplier[0] ? mcand : '0);

        // The dividend is held in quot and shifted out MSB-first as quotient bits shift in.
        rem_shift = {rem, quot[SIZE-1]};
        rem_diff  = rem_shift - {1'b0, divisor};
        if (rem_diff[SIZE]) begin
            rem_step  = rem_shift[SIZE-1:0];
            quot_step = {quot[SIZE-2:0], 1'b0};
        end else begin
            rem_step  = rem_diff[SIZE-1:0];
            quot_step = {quot[SIZE-2:0], 1'b1};
        end

        case (state)
            IDLE: begin
                if (start && cmd == CMD_MULT) begin
                    state_next = MUL;
                end else if (start && cmd == CMD_DIV) begin
                    state_next = DIV;
                end
            end
            MUL: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DIV: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hi       <= '0;
            lo       <= '0;
            count    <= '0;
            dbz_flag <= 1'b0;
            mcand    <= '0;
            acc      <= '0;
            mplier   <= '0;
            divisor  <= '0;
            quot     <= '0;
            rem      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        case (cmd)
                            CMD_MULT: begin
                                mcand    <= {{SIZE{1'b0}}, operand_a};
                                mplier   <= operand_b;
                                acc      <= '0;
                                count    <= '0;
                                dbz_flag <= 1'b0;
                            end
                            CMD_DIV: begin
                                quot     <= operand_a;
                                divisor  <= operand_b;
                                rem      <= '0;
                                count    <= '0;
                                dbz_flag <= (operand_b == '0);
                            end
                            CMD_MTHI: hi <= operand_a;
                            CMD_MTLO: lo <= operand_a;
                            default: ;
                        endcase
                    end
                end
                MUL: begin
                    acc    <= acc_step;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + CNT_W'(1);
                    if (last_step) begin
                        {hi, lo} <= acc_step;
                    end
                end
                DIV: begin
                    rem   <= rem_step;
                    quot  <= quot_step;
                    count <= count + CNT_W'(1);
                    if (last_step) begin
                        hi <= rem_step;
                        lo <= quot_step;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: directed corner cases plus random
// commands compared against a plain-arithmetic model of HI/LO.
module tb_hilo_muldiv_unit;

    localparam int SIZE = 32;
    localparam logic [1:0] C_MULT = 2'd0;
    localparam logic [1:0] C_DIV  = 2'd1;
    localparam logic [1:0] C_MTHI = 2'd2;
    localparam logic [1:0] C_MTLO = 2'd3;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            start;
    logic [1:0]      cmd;
    logic [SIZE-1:0] operand_a;
    logic [SIZE-1:0] operand_b;
    logic            busy;
    logic            done;
    logic            div_by_zero;
    logic [SIZE-1:0] hi;
    logic [SIZE-1:0] lo;

    int checks = 0;
    int errors = 0;

    logic [SIZE-1:0] exp_hi = '0;
    logic [SIZE-1:0] exp_lo = '0;
    logic            exp_dbz = 1'b0;

    hilo_muldiv_unit #(.SIZE(SIZE), .CMD_SIZE(2)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .cmd         (cmd),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Reference behaviour: plain 64-bit arithmetic on the architectural registers.
    task automatic modelOp(input logic [1:0] c, input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
        logic [63:0] prod;
        case (c)
            C_MULT: begin
                prod = 64'(a) * 64'(b);
                exp_hi = prod[63:32];
                exp_lo = prod[31:0];
                exp_dbz = 1'b0;
            end
            C_DIV: begin
                if (b == 0) begin
                    exp_lo = '1;
                    exp_hi = a;
                    exp_dbz = 1'b1;
                end else begin
                    exp_lo = a / b;
                    exp_hi = a % b;
                    exp_dbz = 1'b0;
                end
            end
            C_MTHI: exp_hi = a;
            default: exp_lo = a;
        endcase
    endtask

    // Presents one command for a single edge, then scrambles the operand inputs.
    task automatic applyStimulus(input logic [1:0] c, input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
        start = 1'b1;
        cmd = c;
        operand_a = a;
        operand_b = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        operand_a = $urandom;
        operand_b = $urandom;
    endtask

    task automatic doOp(input string tag, input logic [1:0] c, input logic [SIZE-1:0] a,
                        input logic [SIZE-1:0] b, input bit inject);
        logic [SIZE-1:0] hi_before;
        logic [SIZE-1:0] lo_before;
        int n;
        hi_before = exp_hi;
        lo_before = exp_lo;
        applyStimulus(c, a, b);
        if (c == C_MTHI || c == C_MTLO) begin
            modelOp(c, a, b);
            checkOutput({tag, "_busy"}, 64'(busy), 64'(0));
            checkOutput({tag, "_hi"}, 64'(hi), 64'(exp_hi));
            checkOutput({tag, "_lo"}, 64'(lo), 64'(exp_lo));
            return;
        end
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            if (n == 10) begin
                checkOutput({tag, "_mid_busy"}, 64'(busy), 64'(1));
                checkOutput({tag, "_mid_hi"}, 64'(hi), 64'(hi_before));
                checkOutput({tag, "_mid_lo"}, 64'(lo), 64'(lo_before));
            end
            if (inject && n == 5) begin
                start = 1'b1;
                cmd = ($urandom_range(0, 1) == 0) ? C_MTLO : C_MULT;
                operand_a = $urandom;
                operand_b = $urandom;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            n++;
        end
        start = 1'b0;
        modelOp(c, a, b);
        checkOutput({tag, "_latency"}, 64'(n), 64'(SIZE));
        checkOutput({tag, "_done"}, 64'(done), 64'(1));
        checkOutput({tag, "_dbz"}, 64'(div_by_zero), 64'(exp_dbz));
        checkOutput({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        checkOutput({tag, "_lo"}, 64'(lo), 64'(exp_lo));
        @(posedge clk);
        #1;
        checkOutput({tag, "_done_pulse"}, 64'(done), 64'(0));
        checkOutput({tag, "_idle"}, 64'(busy), 64'(0));
    endtask

    initial begin
        int pulses;
        logic [1:0] rc;
        logic [SIZE-1:0] ra;
        logic [SIZE-1:0] rb;

        reset_n = 1'b0;
        start = 1'b0;
        cmd = '0;
        operand_a = '0;
        operand_b = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_busy", 64'(busy), 64'(0));
        checkOutput("rst_done", 64'(done), 64'(0));
        checkOutput("rst_dbz", 64'(div_by_zero), 64'(0));
        checkOutput("rst_hi", 64'(hi), 64'(0));
        checkOutput("rst_lo", 64'(lo), 64'(0));
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        doOp("mul_max", C_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        checkOutput("mul_max_hi_const", 64'(hi), 64'h0000_0000_FFFF_FFFE);
        doOp("div_100_7", C_DIV, 32'd100, 32'd7, 1'b0);
        checkOutput("div_100_7_lo_const", 64'(lo), 64'd14);
        doOp("div_msb", C_DIV, 32'h8000_0000, 32'd1, 1'b0);
        doOp("div_zero", C_DIV, 32'd5, 32'd0, 1'b0);
        doOp("mul_3_4", C_MULT, 32'd3, 32'd4, 1'b0);
        doOp("mthi", C_MTHI, 32'h1234, 32'd0, 1'b0);
        doOp("mtlo", C_MTLO, 32'hCAFE_F00D, 32'd0, 1'b0);
        doOp("mul_ignore", C_MULT, 32'h0001_0003, 32'h0002_0005, 1'b1);
        doOp("div_ignore", C_DIV, 32'hDEAD_BEEF, 32'h0000_1234, 1'b1);

        // Abort a multiply mid-flight; no done pulse may follow.
        applyStimulus(C_MULT, 32'h1111_1111, 32'h2222_2222);
        repeat (9) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        exp_hi = '0;
        exp_lo = '0;
        checkOutput("abort_busy", 64'(busy), 64'(0));
        checkOutput("abort_hi", 64'(hi), 64'(0));
        checkOutput("abort_lo", 64'(lo), 64'(0));
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) pulses++;
            @(posedge clk);
            #1;
        end
        checkOutput("abort_no_done", 64'(pulses), 64'(0));
        doOp("mul_2_3", C_MULT, 32'd2, 32'd3, 1'b0);

        for (int i = 0; i < 24; i++) begin
            rc = 2'($urandom_range(0, 3));
            ra = $urandom;
            if ($urandom_range(0, 7) == 0) rb = '0;
            else rb = $urandom >> $urandom_range(0, 31);
            doOp($sformatf("rnd%0d", i), rc, ra, rb, ($urandom_range(0, 2) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
